tlul_periph_responder: RTL and testbench



---
 rtl/tl_periph_pkg.sv | 12 +
 rtl/tlul_pkg.sv | 46 ++++
 rtl/tlul_req_chk.sv | 47 ++++
 rtl/tlul_periph_responder.sv | 130 +++++++++++++
 tb/tb_tlul_periph_responder.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/tl_periph_pkg.sv
// Peripheral-port responder types: FSM state encoding and default register address width.
package tl_periph_pkg;

    localparam int unsigned REG_AW_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } responder_state_e;

endpackage

// File: rtl/tlul_pkg.sv
// TL-UL channel structs and opcode enums shared by the crossbar and device adapters.
package tlul_pkg;

    localparam int unsigned TL_AW  = 32;
    localparam int unsigned TL_DW  = 32;
    localparam int unsigned TL_DBW = TL_DW / 8;
    localparam int unsigned TL_SZW = 2;
    localparam int unsigned TL_AIW = 8;
    localparam int unsigned TL_DIW = 1;

    typedef enum logic [2:0] {
        PutFullData    = 3'h0,
        PutPartialData = 3'h1,
        Get            = 3'h4
    } tl_a_op_e;

    typedef enum logic [2:0] {
        AccessAck     = 3'h0,
        AccessAckData = 3'h1
    } tl_d_op_e;

    typedef struct packed {
        logic                a_valid;
        tl_a_op_e            a_opcode;
        logic [2:0]          a_param;
        logic [TL_SZW-1:0]   a_size;
        logic [TL_AIW-1:0]   a_source;
        logic [TL_AW-1:0]    a_address;
        logic [TL_DBW-1:0]   a_mask;
        logic [TL_DW-1:0]    a_data;
        logic                d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic                d_valid;
        tl_d_op_e            d_opcode;
        logic [2:0]          d_param;
        logic [TL_SZW-1:0]   d_size;
        logic [TL_AIW-1:0]   d_source;
        logic [TL_DIW-1:0]   d_sink;
        logic [TL_DW-1:0]    d_data;
        logic                d_error;
        logic                a_ready;
    } tl_d2h_t;

endpackage

// File: rtl/tlul_req_chk.sv
// Combinational TL-UL A-channel legality check for 32-bit device adapters.
module tlul_req_chk
    import tlul_pkg::*;
(
    input  tl_a_op_e            opcode,
    input  logic [TL_SZW-1:0]   size,
    input  logic [1:0]          addr_lsb,
    input  logic [TL_DBW-1:0]   mask,
    output logic                illegal
);

    logic [TL_DBW-1:0] full_mask;
    logic              misaligned;
    logic              op_ok;
    logic              is_write;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        full_mask  = '0;
        misaligned = 1'b0;
        unique case (size)
            2'd0: full_mask = TL_DBW'(1) << addr_lsb;
            2'd1: begin
                full_mask  = TL_DBW'(3) << {addr_lsb[1], 1'b0};
                misaligned = addr_lsb[0];
            end
            2'd2: begin
                full_mask  = '1;
                misaligned = |addr_lsb;
            end
            default: begin
                full_mask  = '0;
                misaligned = 1'b0;
            end
        endcase
    end

    assign op_ok    = opcode inside {Get, PutFullData, PutPartialData};
    assign is_write = opcode inside {PutFullData, PutPartialData};

    assign illegal = !op_ok
                  || (size > TL_SZW'(2))
                  || misaligned
                  || ((opcode == PutFullData) && (mask != full_mask))
                  || (is_write && (mask == '0));

endmodule

// File: rtl/tlul_periph_responder.sv
// TL-UL device-side responder: one outstanding request, mapped onto a simple
// strobe/busy register bus, answered with exactly one D-channel response.
module tlul_periph_responder
    import tlul_pkg::*;
    import tl_periph_pkg::*;
#(
    parameter int unsigned RegAw = REG_AW_DEFAULT,
    parameter int unsigned RegDw = TL_DW
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  tl_h2d_t              tl_i,
    output tl_d2h_t              tl_o,
    output logic                 re_o,
    output logic                 we_o,
    output logic [RegAw-1:0]     addr_o,
    output logic [RegDw-1:0]     wdata_o,
    output logic [RegDw/8-1:0]   be_o,
    input  logic                 busy_i,
    input  logic [RegDw-1:0]     rdata_i,
    input  logic                 error_i
);

    if (RegDw != TL_DW) begin : gen_dw_check
        $error("RegDw must equal the TL-UL data width");
    end
    if (RegAw < 3 || RegAw >= TL_AW) begin : gen_aw_check
        $error("RegAw out of range");
    end

    responder_state_e     state_q, state_d;
    tl_a_op_e             op_q;
    logic [TL_AIW-1:0]    source_q;
    logic [TL_SZW-1:0]    size_q;
    logic [RegAw-3:0]     addr_q;
    logic [RegDw/8-1:0]   mask_q;
    logic [RegDw-1:0]     wdata_q;
    logic [RegDw-1:0]     rdata_q;
    logic                 error_q;

    logic accept;
    logic complete;
    logic illegal;

    // Upper address bits were decoded by the crossbar; a_param carries nothing for TL-UL.
    logic unused_tl;
    assign unused_tl = ^{tl_i.a_param, tl_i.a_address[TL_AW-1:RegAw]};

    tlul_req_chk u_req_chk (
        .opcode   (tl_i.a_opcode),
        .size     (tl_i.a_size),
        .addr_lsb (tl_i.a_address[1:0]),
        .mask     (tl_i.a_mask),
        .illegal  (illegal)
    );

    assign accept   = tl_i.a_valid && (state_q == IDLE);
    assign complete = (state_q == ACCESS) && !busy_i;

    always_comb begin
        state_d = state_q;
        re_o    = 1'b0;
        we_o    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) state_d = illegal ? RESP : ACCESS;
            end
            ACCESS: begin
                re_o = (op_q == Get);
                we_o = (op_q != Get);
                if (!busy_i) state_d = RESP;
            end
            RESP: begin
                if (tl_i.d_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Illegal requests skip ACCESS, so the error seeded here is the one returned.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            op_q     <= PutFullData;
            source_q <= '0;
            size_q   <= '0;
            addr_q   <= '0;
            mask_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            error_q  <= 1'b0;
        end else if (accept) begin
            op_q     <= tl_i.a_opcode;
            source_q <= tl_i.a_source;
            size_q   <= tl_i.a_size;
            addr_q   <= tl_i.a_address[RegAw-1:2];
            mask_q   <= tl_i.a_mask;
            wdata_q  <= tl_i.a_data;
            rdata_q  <= '0;
            error_q  <= illegal;
        end else if (complete) begin
            rdata_q  <= (op_q == Get) ? rdata_i : '0;
            error_q  <= error_i;
        end
    end

    assign addr_o  = {addr_q, 2'b00};
    assign wdata_o = wdata_q;
    assign be_o    = mask_q;

    always_comb begin
        tl_o          = '0;
        tl_o.a_ready  = (state_q == IDLE);
        tl_o.d_valid  = (state_q == RESP);
        tl_o.d_opcode = (op_q == Get) ? AccessAckData : AccessAck;
        tl_o.d_size   = size_q;
        tl_o.d_source = source_q;
        tl_o.d_data   = rdata_q;
        tl_o.d_error  = error_q;
    end

endmodule

// File: tb/tb_tlul_periph_responder.sv
// Randomized self-checking bench for tlul_periph_responder against a transaction-level model.
module tb_tlul_periph_responder;
    import tlul_pkg::*;

    localparam int RegAw = 8;
    localparam int RegDw = 32;

    logic               clk = 1'b0;
    logic               rst_ni;
    tl_h2d_t            tl_i;
    tl_d2h_t            tl_o;
    logic               re_o, we_o;
    logic [RegAw-1:0]   addr_o;
    logic [RegDw-1:0]   wdata_o;
    logic [RegDw/8-1:0] be_o;
    logic               busy_i;
    logic [RegDw-1:0]   rdata_i;
    logic               error_i;

    int n_cmp = 0;
    int n_mis = 0;

    typedef struct {
        logic [2:0]  op;
        logic [7:0]  src;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [3:0]  mask;
        logic [31:0] data;
        int          busy;
        logic [31:0] rdata;
        logic        err;
        int          hold;
        bit          pend;
    } txn_t;

    txn_t next_req;

    tlul_periph_responder #(.RegAw(RegAw), .RegDw(RegDw)) dut (
        .clk_i   (clk),
        .rst_ni  (rst_ni),
        .tl_i    (tl_i),
        .tl_o    (tl_o),
        .re_o    (re_o),
        .we_o    (we_o),
        .addr_o  (addr_o),
        .wdata_o (wdata_o),
        .be_o    (be_o),
        .busy_i  (busy_i),
        .rdata_i (rdata_i),
        .error_i (error_i)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference legality rule, computed from sizes in bytes and lane offsets.
    function automatic bit model_legal(input txn_t t);
        int nbytes;
        int lane;
        if (!(t.op == 3'd0 || t.op == 3'd1 || t.op == 3'd4)) return 1'b0;
        if (t.size > 2) return 1'b0;
        nbytes = 1 << t.size;
        lane   = t.addr % 4;
        if (t.addr % nbytes != 0) return 1'b0;
        if (t.op == 3'd0 && int'(t.mask) != (((1 << nbytes) - 1) << lane)) return 1'b0;
        if (t.op != 3'd4 && t.mask == 4'd0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic scramble_a();
        tl_i.a_valid   = 1'b0;
        tl_i.a_opcode  = tl_a_op_e'(3'($urandom));
        tl_i.a_size    = 2'($urandom);
        tl_i.a_source  = 8'($urandom);
        tl_i.a_address = $urandom;
        tl_i.a_mask    = 4'($urandom);
        tl_i.a_data    = $urandom;
    endtask

    task automatic drive_a(input txn_t t);
        tl_i.a_valid   = 1'b1;
        tl_i.a_opcode  = tl_a_op_e'(t.op);
        tl_i.a_size    = t.size;
        tl_i.a_source  = t.src;
        tl_i.a_address = t.addr;
        tl_i.a_mask    = t.mask;
        tl_i.a_data    = t.data;
    endtask

    task automatic run_txn(input txn_t t);
        bit          legal;
        bit          is_get;
        logic [31:0] exp_data;
        logic        exp_err;
        logic [31:0] exp_addr;
        legal    = model_legal(t);
        is_get   = (t.op == 3'd4);
        exp_data = (legal && is_get) ? t.rdata : 32'd0;
        exp_err  = legal ? t.err : 1'b1;
        exp_addr = (t.addr % 256) / 4 * 4;

        @(negedge clk);
        check("a_ready_idle", tl_o.a_ready, 1);
        check("d_valid_idle", tl_o.d_valid, 0);
        check("strobe_idle", {re_o, we_o}, 0);
        drive_a(t);
        tl_i.d_ready = 1'b0;
        busy_i = 1'($urandom);

        if (legal) begin
            for (int i = 0; i <= t.busy; i++) begin
                @(negedge clk);
                if (i == 0) scramble_a();
                busy_i  = (i < t.busy);
                rdata_i = (i == t.busy) ? t.rdata : $urandom;
                error_i = (i == t.busy) ? t.err : 1'($urandom);
                check("re_o", re_o, is_get);
                check("we_o", we_o, !is_get);
                check("addr_o", addr_o, exp_addr);
                check("wdata_o", wdata_o, t.data);
                check("be_o", be_o, t.mask);
                check("a_ready_access", tl_o.a_ready, 0);
                check("d_valid_access", tl_o.d_valid, 0);
            end
        end

        for (int j = 0; j <= t.hold; j++) begin
            @(negedge clk);
            if (j == 0) scramble_a();
            if (t.pend) drive_a(next_req);
            busy_i  = 1'($urandom);
            rdata_i = $urandom;
            error_i = 1'($urandom);
            check("d_valid", tl_o.d_valid, 1);
            check("d_opcode", tl_o.d_opcode, is_get ? 1 : 0);
            check("d_source", tl_o.d_source, t.src);
            check("d_size", tl_o.d_size, t.size);
            check("d_data", tl_o.d_data, exp_data);
            check("d_error", tl_o.d_error, exp_err);
            check("a_ready_resp", tl_o.a_ready, 0);
            check("strobe_resp", {re_o, we_o}, 0);
            tl_i.d_ready = (j == t.hold);
        end
    endtask

    function automatic txn_t mk(input logic [2:0] op, input logic [7:0] src, input logic [1:0] size,
                                input logic [31:0] addr, input logic [3:0] mask, input logic [31:0] data,
                                input int busy, input logic [31:0] rdata, input logic err, input int hold);
        txn_t t;
        t.op = op; t.src = src; t.size = size; t.addr = addr; t.mask = mask; t.data = data;
        t.busy = busy; t.rdata = rdata; t.err = err; t.hold = hold; t.pend = 1'b0;
        return t;
    endfunction

    function automatic txn_t rand_txn();
        txn_t t;
        int   r;
        int   nbytes;
        r = $urandom_range(0, 9);
        if (r < 4)      t.op = 3'd4;
        else if (r < 6) t.op = 3'd0;
        else if (r < 8) t.op = 3'd1;
        else            t.op = 3'($urandom);
        t.size = ($urandom_range(0, 9) < 8) ? 2'($urandom_range(0, 2)) : 2'd3;
        nbytes = 1 << t.size;
        t.addr = $urandom;
        if ($urandom_range(0, 3) != 0) t.addr = t.addr - t.addr % nbytes;
        if (t.op == 3'd0 && $urandom_range(0, 4) != 0)
            t.mask = 4'(((1 << nbytes) - 1) << (t.addr % 4));
        else
            t.mask = 4'($urandom);
        t.src   = 8'($urandom);
        t.data  = $urandom;
        t.busy  = $urandom_range(0, 3);
        t.rdata = $urandom;
        t.err   = ($urandom_range(0, 3) == 0);
        t.hold  = $urandom_range(0, 3);
        t.pend  = 1'b0;
        return t;
    endfunction

    initial begin
        txn_t t;
        rst_ni       = 1'b0;
        scramble_a();
        tl_i.a_param = 3'd0;
        tl_i.d_ready = 1'b0;
        busy_i       = 1'b0;
        rdata_i      = '0;
        error_i      = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_a_ready", tl_o.a_ready, 1);
        check("rst_d_valid", tl_o.d_valid, 0);
        check("rst_strobe", {re_o, we_o}, 0);
        check("rst_addr", addr_o, 0);
        check("rst_wdata", wdata_o, 0);
        check("rst_be", be_o, 0);
        check("rst_d_data", tl_o.d_data, 0);
        check("rst_d_error", tl_o.d_error, 0);
        check("rst_d_source", tl_o.d_source, 0);
        check("rst_d_size", tl_o.d_size, 0);
        rst_ni = 1'b1;

        // Directed: plain read, stalled partial write, three illegal forms.
        run_txn(mk(3'd4, 8'h2A, 2'd2, 32'h04, 4'hF, 32'h0, 0, 32'hDEADBEEF, 1'b0, 0));
        run_txn(mk(3'd1, 8'h13, 2'd2, 32'h08, 4'b0110, 32'h11223344, 3, 32'h0, 1'b0, 1));
        run_txn(mk(3'd3, 8'h31, 2'd2, 32'h0C, 4'hF, 32'h0, 0, 32'h0, 1'b0, 0));
        run_txn(mk(3'd4, 8'h32, 2'd2, 32'h02, 4'hF, 32'h0, 0, 32'h0, 1'b0, 0));
        run_txn(mk(3'd0, 8'h33, 2'd2, 32'h10, 4'b0111, 32'h55, 0, 32'h0, 1'b0, 0));

        // Back-pressure with a request waiting, then a write that sees error_i.
        t = mk(3'd4, 8'h40, 2'd2, 32'h14, 4'hF, 32'h0, 0, 32'hCAFEF00D, 1'b0, 5);
        t.pend = 1'b1;
        next_req = mk(3'd0, 8'h41, 2'd2, 32'h18, 4'hF, 32'hA5A5A5A5, 0, 32'h0, 1'b1, 0);
        run_txn(t);
        run_txn(next_req);

        // Reset pulsed while a stalled read is in ACCESS.
        @(negedge clk);
        drive_a(mk(3'd4, 8'h50, 2'd2, 32'h20, 4'hF, 32'h0, 0, 32'h0, 1'b0, 0));
        tl_i.d_ready = 1'b0;
        @(negedge clk);
        scramble_a();
        busy_i = 1'b1;
        check("pre_rst_re", re_o, 1);
        @(negedge clk);
        rst_ni = 1'b0;
        #1;
        check("mid_rst_strobe", {re_o, we_o}, 0);
        check("mid_rst_d_valid", tl_o.d_valid, 0);
        check("mid_rst_a_ready", tl_o.a_ready, 1);
        @(negedge clk);
        rst_ni = 1'b1;
        busy_i = 1'b0;
        run_txn(mk(3'd4, 8'h51, 2'd2, 32'h24, 4'hF, 32'h0, 1, 32'h0BADF00D, 1'b0, 0));

        for (int n = 0; n < 300; n++) begin
            run_txn(rand_txn());
            if ($urandom_range(0, 2) == 0) begin
                @(negedge clk);
                scramble_a();
                tl_i.d_ready = 1'($urandom);
                check("gap_a_ready", tl_o.a_ready, 1);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
